// File: rtl/adt7420_temp_reader.sv
// Periodic I2C master: reads the ADT7420 temperature register pair and
// presents whole degrees Celsius, clamped to 0..255, for the decimal display.
module adt7420_temp_reader #(
    parameter int         CLK_HZ        = 100_000_000,
    parameter int         I2C_HZ        = 100_000,
    parameter int         SAMPLE_CYCLES = 25_000_000,
    parameter logic [6:0] DEV_ADDR      = 7'h4B
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i,
    output logic [7:0] temp_c,
    output logic       temp_valid,
    output logic       busy,
    output logic       ack_err
);

    localparam int QDIV = CLK_HZ / (4 * I2C_HZ);
    localparam int QW   = $clog2(QDIV + 1);
    localparam int TW   = $clog2(SAMPLE_CYCLES + 1);
    localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);
    localparam logic [TW-1:0] TLAST = TW'(SAMPLE_CYCLES - 1);
    localparam logic [7:0] ADDR_W = {DEV_ADDR, 1'b0};
    localparam logic [7:0] ADDR_R = {DEV_ADDR, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_TX, S_ACK, S_RSTART,
        S_RX, S_MACK, S_MNACK, S_STOP, S_DONE
    } state_t;

    state_t        state;
    logic [QW-1:0] qcnt;
    logic [1:0]    q;
    logic [2:0]    bit_cnt;
    logic [2:0]    byte_idx;
    logic [TW-1:0] tcnt;
    logic          nack;
    logic          fail;
    logic          sda_s1;
    logic          sda_s2;
    logic [7:0]    tx_sh;
    logic [7:0]    rx_sh;
    logic [7:0]    msb;

    logic tick;
    logic expire;
    logic sample_pt;
    logic bit_end;

    assign tick      = (qcnt == QLAST);
    assign expire    = (tcnt == TLAST);
    assign sample_pt = tick && (q == 2'd2);
    assign bit_end   = tick && (q == 2'd3);

    // Integer part is raw[15:7] of the 13-bit reading; negatives clamp to 0.
    function automatic logic [7:0] to_celsius(input logic [8:0] whole9);
        logic signed [9:0] whole;
        whole = {whole9[8], whole9};
        if (whole < 10'sd0)
            return 8'd0;
        else if (whole > 10'sd255)
            return 8'hFF;
        else
            return whole[7:0];
    endfunction

    // SCL is released in Q2/Q3 of data bits; START/Sr/STOP shape their own bit.
    function automatic logic scl_drive(input state_t s, input logic [1:0] qq);
        case (s)
            S_TX, S_ACK, S_RX, S_MACK, S_MNACK: return (qq < 2'd2);
            S_RSTART, S_STOP:                   return (qq == 2'd0);
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic sda_drive(input state_t s, input logic [1:0] qq,
                                       input logic tx_bit);
        case (s)
            S_START, S_RSTART: return (qq >= 2'd2);
            S_TX:              return ~tx_bit;
            S_MACK:            return 1'b1;
            S_STOP:            return (qq < 2'd2);
            default:           return 1'b0;
        endcase
    endfunction

    // Free-running sample period; expiries while busy simply pass by.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tcnt <= '0;
        else if (expire)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            qcnt       <= '0;
            q          <= '0;
            bit_cnt    <= '0;
            byte_idx   <= '0;
            nack       <= 1'b0;
            fail       <= 1'b0;
            sda_s1     <= 1'b1;
            sda_s2     <= 1'b1;
            scl_oe     <= 1'b0;
            sda_oe     <= 1'b0;
            temp_c     <= 8'd0;
            temp_valid <= 1'b0;
            busy       <= 1'b0;
            ack_err    <= 1'b0;
        end else begin
            sda_s1     <= sda_i;
            sda_s2     <= sda_s1;
            scl_oe     <= scl_drive(state, q);
            sda_oe     <= sda_drive(state, q, tx_sh[7]);
            temp_valid <= 1'b0;

            if (state == S_IDLE || state == S_DONE) begin
                qcnt <= '0;
                q    <= '0;
            end else if (tick) begin
                qcnt <= '0;
                q    <= q + 2'd1;
            end else begin
                qcnt <= qcnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (expire) begin
                        state    <= S_START;
                        busy     <= 1'b1;
                        fail     <= 1'b0;
                        bit_cnt  <= '0;
                        byte_idx <= '0;
                    end
                end
                S_START, S_RSTART: begin
                    if (bit_end)
                        state <= S_TX;
                end
                S_TX: begin
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (sample_pt)
                        nack <= sda_s2;
                    if (bit_end) begin
                        if (nack) begin
                            ack_err <= 1'b1;
                            fail    <= 1'b1;
                            state   <= S_STOP;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            case (byte_idx)
                                3'd0:    state <= S_TX;
                                3'd1:    state <= S_RSTART;
                                default: state <= S_RX;
                            endcase
                        end
                    end
                end
                S_RX: begin
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= (byte_idx == 3'd3) ? S_MACK : S_MNACK;
                    end
                end
                S_MACK: begin
                    if (bit_end) begin
                        byte_idx <= byte_idx + 3'd1;
                        state    <= S_RX;
                    end
                end
                S_MNACK: begin
                    if (bit_end)
                        state <= S_STOP;
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (fail) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state      <= S_DONE;
                            temp_c     <= to_celsius({msb, rx_sh[7]});
                            temp_valid <= 1'b1;
                            ack_err    <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Byte shifters; loaded at the end of the bit that precedes each TX byte.
    always_ff @(posedge clk) begin
        if (tick) begin
            case (state)
                S_START:  if (q == 2'd3) tx_sh <= ADDR_W;
                S_RSTART: if (q == 2'd3) tx_sh <= ADDR_R;
                S_ACK:    if (q == 2'd3) tx_sh <= 8'h00;
                S_TX:     if (q == 2'd3) tx_sh <= {tx_sh[6:0], 1'b0};
                S_RX:     if (q == 2'd2) rx_sh <= {rx_sh[6:0], sda_s2};
                S_MACK:   if (q == 2'd3) msb <= rx_sh;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adt7420_temp_reader.sv
// Bench for adt7420_temp_reader: behavioural ADT7420 slave, bus monitor and
// a table of readings with hand-computed expected temperatures.
module tb_adt7420_temp_reader;

    localparam int CLK_HZ = 1600;
    localparam int I2C_HZ = 100;
    localparam int SAMPLE = 1000;
    localparam int BITCLK = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_oe, sda_oe, sda_i;
    logic [7:0] temp_c;
    logic       temp_valid, busy, ack_err;

    logic slv_drive = 1'b0;
    logic scl_line, sda_line;
    assign scl_line = ~scl_oe;
    assign sda_line = ~(sda_oe | slv_drive);
    assign sda_i    = sda_line;

    always #5 clk = ~clk;

    adt7420_temp_reader #(
        .CLK_HZ(CLK_HZ), .I2C_HZ(I2C_HZ), .SAMPLE_CYCLES(SAMPLE), .DEV_ADDR(7'h4B)
    ) dut (
        .clk(clk), .rst_n(rst_n), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i),
        .temp_c(temp_c), .temp_valid(temp_valid), .busy(busy), .ack_err(ack_err)
    );

    logic [7:0] cfg_msb = 8'h0C;
    logic [7:0] cfg_lsb = 8'h80;
    bit         cfg_nack = 1'b0;

    // Slave model state and bus statistics for the current transaction
    logic       s_scl, s_sda, prev_scl = 1'b1, prev_sda = 1'b1;
    int         bitn = 0, rd_idx = 0, nrx = 0, nmack = 0, nstart = 0, nstop = 0;
    int         per_ok = 0, per_bad = 0, cyc = 0, last_rise = 0, vtotal = 0;
    bit         ackslot = 0, rd = 0, rd_pend = 0, is_addr = 0, in_txn = 0, send_next = 0;
    logic [7:0] shift = 8'h00, txb = 8'h00;
    logic [7:0] rx_bytes [0:7];
    bit         macks [0:3];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n && temp_valid) vtotal = vtotal + 1;
        if (!rst_n) begin
            slv_drive = 1'b0; in_txn = 0; ackslot = 0; bitn = 0; rd = 0; rd_pend = 0;
            prev_scl = 1'b1; prev_sda = 1'b1;
        end else begin
            s_scl = scl_line;
            s_sda = sda_line;
            if (prev_scl && s_scl && prev_sda && !s_sda) begin
                if (!in_txn) begin
                    nrx = 0; nmack = 0; nstart = 0; nstop = 0; per_ok = 0; per_bad = 0;
                end
                nstart = nstart + 1;
                in_txn = 1; bitn = 0; ackslot = 0; rd = 0; rd_pend = 0; is_addr = 1;
                slv_drive = 1'b0;
            end else if (prev_scl && s_scl && !prev_sda && s_sda) begin
                nstop = nstop + 1;
                in_txn = 0;
                slv_drive = 1'b0;
            end else if (!prev_scl && s_scl) begin
                if (ackslot || bitn >= 1) begin
                    if (cyc - last_rise == BITCLK) per_ok = per_ok + 1;
                    else per_bad = per_bad + 1;
                end
                last_rise = cyc;
                if (ackslot) begin
                    if (rd) begin
                        if (nmack < 4) macks[nmack] = s_sda;
                        nmack = nmack + 1;
                        send_next = !s_sda;
                    end
                end else begin
                    shift = {shift[6:0], s_sda};
                    bitn = bitn + 1;
                end
            end else if (prev_scl && !s_scl && in_txn) begin
                if (ackslot) begin
                    ackslot = 0; bitn = 0; slv_drive = 1'b0;
                    if (rd_pend) begin
                        rd = 1; rd_pend = 0; send_next = 1; rd_idx = 0;
                    end
                    if (rd && send_next) begin
                        txb = (rd_idx == 0) ? cfg_msb : cfg_lsb;
                        rd_idx = rd_idx + 1;
                        slv_drive = ~txb[7];
                    end
                end else if (bitn == 8) begin
                    ackslot = 1;
                    if (!rd) begin
                        if (nrx < 8) rx_bytes[nrx] = shift;
                        nrx = nrx + 1;
                        slv_drive = !(cfg_nack && nrx == 1);
                        if (is_addr && shift[0] && slv_drive) rd_pend = 1;
                        is_addr = 0;
                    end else begin
                        slv_drive = 1'b0;
                    end
                end else if (rd && bitn > 0) begin
                    slv_drive = ~txb[7 - bitn];
                end
            end
            prev_scl = s_scl;
            prev_sda = s_sda;
        end
    end

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input int act, input int exp);
        compared = compared + 1;
        if (act != exp) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, input int lim, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== lvl && n < lim) begin
            @(negedge clk);
            n = n + 1;
        end
        if (busy !== lvl) check(name, int'(busy), int'(lvl));
    endtask

    task automatic count_to_start(input string name);
        int n;
        n = 0;
        while (n < 3 * SAMPLE) begin
            @(posedge clk);
            n = n + 1;
            #1;
            if (busy) break;
        end
        check(name, n, SAMPLE);
    endtask

    typedef struct {
        logic [7:0] msb;
        logic [7:0] lsb;
        bit         nack;
        int         exp_temp;
        int         exp_valid;
        int         exp_err;
    } vec_t;

    vec_t vecs [0:8];

    initial begin
        int vbase;
        int n;
        vecs[0] = '{8'h0C, 8'h80, 1'b0,  25, 1, 0};
        vecs[1] = '{8'h4B, 8'h00, 1'b0, 150, 1, 0};
        vecs[2] = '{8'hFB, 8'h00, 1'b0,   0, 1, 0};
        vecs[3] = '{8'h0C, 8'hF8, 1'b0,  25, 1, 0};
        vecs[4] = '{8'h00, 8'h7F, 1'b0,   0, 1, 0};
        vecs[5] = '{8'h7F, 8'h80, 1'b0, 255, 1, 0};
        vecs[6] = '{8'h0C, 8'h80, 1'b1, 255, 0, 1};
        vecs[7] = '{8'h19, 8'h00, 1'b0,  50, 1, 0};
        vecs[8] = '{8'h0C, 8'h80, 1'b1,  50, 0, 1};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl_oe", int'(scl_oe), 0);
        check("rst_sda_oe", int'(sda_oe), 0);
        check("rst_temp_c", int'(temp_c), 0);
        check("rst_valid", int'(temp_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ack_err", int'(ack_err), 0);

        cfg_msb = vecs[0].msb; cfg_lsb = vecs[0].lsb; cfg_nack = vecs[0].nack;
        @(negedge clk);
        rst_n = 1'b1;
        count_to_start("first_start_delay");

        for (int i = 0; i < 9; i++) begin
            cfg_msb = vecs[i].msb; cfg_lsb = vecs[i].lsb; cfg_nack = vecs[i].nack;
            vbase = vtotal;
            wait_busy(1'b1, 2 * SAMPLE, $sformatf("v%0d_busy_rise", i));
            wait_busy(1'b0, 2 * SAMPLE, $sformatf("v%0d_busy_fall", i));
            @(negedge clk);
            check($sformatf("v%0d_temp_c", i), int'(temp_c), vecs[i].exp_temp);
            check($sformatf("v%0d_valid_pulses", i), vtotal - vbase, vecs[i].exp_valid);
            check($sformatf("v%0d_ack_err", i), int'(ack_err), vecs[i].exp_err);
            check($sformatf("v%0d_addr_w", i), int'(rx_bytes[0]), 8'h96);
            check($sformatf("v%0d_stops", i), nstop, 1);
            check($sformatf("v%0d_scl_period_bad", i), per_bad, 0);
            if (vecs[i].nack) begin
                check($sformatf("v%0d_bytes", i), nrx, 1);
                check($sformatf("v%0d_starts", i), nstart, 1);
                check($sformatf("v%0d_scl_periods", i), per_ok, 8);
            end else begin
                check($sformatf("v%0d_bytes", i), nrx, 3);
                check($sformatf("v%0d_pointer", i), int'(rx_bytes[1]), 8'h00);
                check($sformatf("v%0d_addr_r", i), int'(rx_bytes[2]), 8'h97);
                check($sformatf("v%0d_starts", i), nstart, 2);
                check($sformatf("v%0d_scl_periods", i), per_ok, 40);
                check($sformatf("v%0d_master_acks", i), nmack, 2);
                check($sformatf("v%0d_msb_ack", i), int'(macks[0]), 0);
                check($sformatf("v%0d_lsb_nack", i), int'(macks[1]), 1);
            end
        end

        // Reset in the middle of the MSB read byte
        cfg_msb = 8'h0C; cfg_lsb = 8'h80; cfg_nack = 1'b0;
        wait_busy(1'b1, 2 * SAMPLE, "mid_busy_rise");
        n = 0;
        while (!(rd && rd_idx == 1 && bitn >= 2) && n < 3 * SAMPLE) begin
            @(negedge clk);
            n = n + 1;
        end
        check("mid_reached_msb", int'(rd && rd_idx == 1 && bitn >= 2), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_scl_oe", int'(scl_oe), 0);
        check("mid_sda_oe", int'(sda_oe), 0);
        check("mid_busy", int'(busy), 0);
        check("mid_temp_c", int'(temp_c), 0);
        check("mid_ack_err", int'(ack_err), 0);
        check("mid_valid", int'(temp_valid), 0);
        repeat (3) @(negedge clk);
        vbase = vtotal;
        rst_n = 1'b1;
        count_to_start("restart_delay");
        wait_busy(1'b0, 2 * SAMPLE, "restart_busy_fall");
        @(negedge clk);
        check("restart_temp_c", int'(temp_c), 25);
        check("restart_valid_pulses", vtotal - vbase, 1);
        check("restart_ack_err", int'(ack_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
